// File: rtl/seq_det_pkg.sv
// Shared constants, state encoding and config helpers for the programmable
// serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DefMaxLen = 8;
  localparam int unsigned DefLenW   = 4;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefToW    = 16;

  // Run-controller states.
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // A pattern length is usable only if it is in 1..max_len.
  function automatic logic valid_len(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and length-masked comparator. 'match' is
// combinational and flags that the bit currently shifted in completes the pattern.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = DefMaxLen,
  parameter int unsigned LENW   = DefLenW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              in_bit,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   len,
  input  logic              overlap,
  output logic              match
);

  localparam logic [LENW-1:0] FillMax = LENW'(MAXLEN - 1);

  logic [MAXLEN-2:0] hist_q, hist_d;
  logic [LENW-1:0]   fill_q, fill_d;
  logic [MAXLEN-1:0] window;
  logic [MAXLEN-1:0] mask;
  logic              fill_ok;
  logic              hit;

  // Compare the newest len bits (history plus the incoming bit) against the pattern.
  always_comb begin
    window  = {hist_q, in_bit};
    mask    = ~({MAXLEN{1'b1}} << len);
    fill_ok = fill_q >= (len - LENW'(1));
    hit     = shift_en & fill_ok & ((window & mask) == (pattern & mask));
  end

  assign match = hit;

  // Shift history and advance fill; a non-overlapping hit restarts fill so the
  // completing bit cannot count toward the next match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = window[MAXLEN-2:0];
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + LENW'(1);
      end
    end
  end

  // History and fill registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the programmable pattern detector: latches a run
// configuration on start, counts matches, and finishes with done or timeout.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = DefMaxLen,
  parameter int unsigned LENW   = DefLenW,
  parameter int unsigned CNTW   = DefCntW,
  parameter int unsigned TOW    = DefToW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  input  logic [TOW-1:0]    cfg_timeout,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              cfg_err,
  output logic [CNTW-1:0]   match_count
);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pattern_q, pattern_d;
  logic [LENW-1:0]   len_q, len_d;
  logic              overlap_q, overlap_d;
  logic [CNTW-1:0]   target_q, target_d;
  logic [TOW-1:0]    to_lim_q, to_lim_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [TOW-1:0]    to_cnt_q, to_cnt_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;
  logic              err_q, err_d;

  logic              core_clr;
  logic              core_hit;
  logic              len_ok;
  logic [CNTW-1:0]   cnt_inc;
  logic [TOW-1:0]    to_inc;

  assign busy        = (state_q == StRun);
  assign done        = done_q;
  assign timeout     = tout_q;
  assign cfg_err     = err_q;
  assign match_count = cnt_q;

  assign len_ok  = valid_len(32'(cfg_len), MAXLEN);
  assign cnt_inc = cnt_q + CNTW'(1);
  assign to_inc  = to_cnt_q + TOW'(1);

  // A zero target ends the run without counting, so its single RUN cycle shows no match.
  assign match = busy & core_hit & (target_q != '0);

  seq_match_core #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (core_clr),
    .shift_en (busy & in_valid),
    .in_bit   (in_bit),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .match    (core_hit)
  );

  // FSM, config latch, match/timeout counters and status flags.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    target_d  = target_q;
    to_lim_d  = to_lim_q;
    cnt_d     = cnt_q;
    to_cnt_d  = to_cnt_q;
    done_d    = done_q;
    tout_d    = tout_q;
    err_d     = 1'b0;
    core_clr  = 1'b0;

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      tout_d  = 1'b0;
    end else if ((state_q != StRun) && start && !abort) begin
      if (len_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        target_d  = cfg_target;
        to_lim_d  = cfg_timeout;
        cnt_d     = '0;
        to_cnt_d  = '0;
        done_d    = 1'b0;
        tout_d    = 1'b0;
        core_clr  = 1'b1;
        state_d   = StRun;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == StRun) begin
      if (target_q == '0) begin
        state_d = StDone;
        done_d  = 1'b1;
      end else if (match) begin
        // A match always beats a timeout landing in the same cycle.
        cnt_d    = cnt_inc;
        to_cnt_d = '0;
        if (cnt_inc == target_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end else begin
        to_cnt_d = to_inc;
        if ((to_lim_q != '0) && (to_inc == to_lim_q)) begin
          state_d = StDone;
          tout_d  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      to_lim_q  <= '0;
      cnt_q     <= '0;
      to_cnt_q  <= '0;
      done_q    <= 1'b0;
      tout_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      target_q  <= target_d;
      to_lim_q  <= to_lim_d;
      cnt_q     <= cnt_d;
      to_cnt_q  <= to_cnt_d;
      done_q    <= done_d;
      tout_q    <= tout_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a queue-based reference model.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic [15:0] cfg_timeout;
  logic       start, abort, in_valid, in_bit;
  logic       match, busy, done, timeout, cfg_err;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: runs are described by the list of valid bits since the
  // run began (or since the last non-overlapping match), capped at 7 entries.
  int        m_state = 0;  // 0 idle, 1 run, 2 done
  int        m_cnt   = 0;
  int        m_to    = 0;
  bit        m_done  = 0;
  bit        m_tout  = 0;
  bit        m_err   = 0;
  bit        m_q[$];
  bit [7:0]  m_pat;
  int        m_len;
  bit        m_ovl;
  int        m_tgt;
  int        m_lim;
  bit        exp_match;

  seq_det_ctrl u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match();
    bit b;
    if (m_state != 1 || !in_valid || m_tgt == 0) return 1'b0;
    if (m_q.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? in_bit : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_update();
    bit err_n = 1'b0;
    if (!rstn) begin
      m_state = 0; m_cnt = 0; m_to = 0; m_done = 0; m_tout = 0; m_err = 0;
      m_q.delete();
      return;
    end
    if (abort && m_state != 0) begin
      m_state = 0; m_done = 0; m_tout = 0;
    end else if (m_state != 1 && start && !abort) begin
      if (cfg_len >= 1 && cfg_len <= 8) begin
        m_pat = cfg_pattern; m_len = cfg_len; m_ovl = cfg_overlap;
        m_tgt = cfg_target;  m_lim = cfg_timeout;
        m_cnt = 0; m_to = 0; m_done = 0; m_tout = 0;
        m_q.delete();
        m_state = 1;
      end else begin
        err_n = 1'b1;
      end
    end else if (m_state == 1) begin
      if (m_tgt == 0) begin
        m_state = 2; m_done = 1;
      end else begin
        if (in_valid) begin
          if (exp_match && !m_ovl) m_q.delete();
          else begin
            m_q.push_back(in_bit);
            if (m_q.size() > 7) void'(m_q.pop_front());
          end
        end
        if (exp_match) begin
          m_cnt++; m_to = 0;
          if (m_cnt == m_tgt) begin m_state = 2; m_done = 1; end
        end else begin
          m_to++;
          if (m_lim != 0 && m_to == m_lim) begin m_state = 2; m_tout = 1; end
        end
      end
    end
    m_err = err_n;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic tick();
    @(negedge clk);
    exp_match = model_match();
    check_val("match",   match,       exp_match);
    check_val("busy",    busy,        m_state == 1);
    check_val("done",    done,        m_done);
    check_val("timeout", timeout,     m_tout);
    check_val("cfg_err", cfg_err,     m_err);
    check_val("count",   match_count, m_cnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc(input bit st, input bit ab, input bit v, input bit b);
    start = st; abort = ab; in_valid = v; in_bit = b;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic set_cfg(input bit [7:0] p, input bit [3:0] l, input bit o,
                         input bit [7:0] t, input bit [15:0] lim);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = lim;
  endtask

  initial begin
    bit [7:0] a5;
    rstn = 1'b0; start = 0; abort = 0; in_valid = 0; in_bit = 0;
    set_cfg(8'h00, 4'd1, 1'b0, 8'd1, 16'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_count", match_count, 8'd0);
    rstn = 1'b1;

    // Non-overlapping "101" on 1,0,1,0,1.
    set_cfg(8'h05, 4'd3, 1'b0, 8'd4, 16'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    check_val("s1_count", match_count, 8'd1);
    check_val("s1_busy", busy, 1'b1);
    cyc(0, 1, 0, 0);

    // Overlapping, target 2.
    set_cfg(8'h05, 4'd3, 1'b1, 8'd2, 16'd0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    check_val("s2_done", done, 1'b1);
    check_val("s2_busy", busy, 1'b0);
    check_val("s2_count", match_count, 8'd2);

    // Timeout with no valid input.
    set_cfg(8'h01, 4'd1, 1'b0, 8'd1, 16'd5);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    check_val("s3_timeout", timeout, 1'b1);
    check_val("s3_done", done, 1'b0);
    check_val("s3_count", match_count, 8'd0);

    // 8-bit pattern with gaps on in_valid.
    set_cfg(8'hA5, 4'd8, 1'b0, 8'd2, 16'd0);
    a5 = 8'hA5;
    cyc(1, 0, 0, 0);
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 0, 0, 1'($urandom_range(0, 1)));
      cyc(0, 0, 1, a5[i]);
    end
    check_val("s4_count", match_count, 8'd1);
    cyc(0, 1, 0, 0);

    // Invalid lengths.
    set_cfg(8'h01, 4'd0, 1'b0, 8'd1, 16'd0);
    cyc(1, 0, 0, 0);
    check_val("len0_err", cfg_err, 1'b1);
    check_val("len0_busy", busy, 1'b0);
    set_cfg(8'h01, 4'd9, 1'b0, 8'd1, 16'd0);
    cyc(1, 0, 0, 0);
    check_val("len9_err", cfg_err, 1'b1);
    check_val("len9_busy", busy, 1'b0);

    // Zero target: one RUN cycle then done.
    set_cfg(8'h01, 4'd1, 1'b0, 8'd0, 16'd0);
    cyc(1, 0, 0, 0);
    check_val("t0_busy", busy, 1'b1);
    cyc(0, 0, 1, 1);
    check_val("t0_done", done, 1'b1);

    // Abort with start from idle.
    cyc(0, 1, 0, 0);
    set_cfg(8'h01, 4'd1, 1'b0, 8'd5, 16'd0);
    cyc(1, 1, 0, 0);
    check_val("ab_idle_busy", busy, 1'b0);

    // Abort after two matches.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    check_val("ab_run_busy", busy, 1'b0);
    check_val("ab_run_count", match_count, 8'd2);
    check_val("ab_run_done", done, 1'b0);

    // Reset mid-run.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    rstn = 1'b0;
    cyc(0, 0, 1, 1);
    rstn = 1'b1;
    check_val("rst_mid_busy", busy, 1'b0);
    check_val("rst_mid_count", match_count, 8'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        cfg_target  = 8'($urandom_range(0, 5));
        cfg_timeout = 16'($urandom_range(0, 12));
      end
      rstn = ($urandom_range(0, 299) != 0);
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      rstn = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detection controller for the sequence-detector family. It latches a run configuration on a start request: pattern, length 1..MAXLEN, overlapping/non-overlapping mode, match target and idle timeout. It then monitors a qualified serial bit stream and emits a Mealy-style per-bit match pulse. It counts matches and ends the run with done or timeout status. It sits between a host or config register block and the serial bit source, and replaces fixed-pattern detector instances.

Parameters:
MAXLEN, 8, maximum pattern length in bits
LENW, 4, width of cfg_len (holds 0..MAXLEN)
CNTW, 8, width of match target and match counter
TOW, 16, width of timeout limit and timeout counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
cfg_pattern  in  MAXLEN  pattern; bit cfg_len-1 is the first bit received, bit 0 the last
cfg_len  in  LENW  pattern length; valid range 1..MAXLEN
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNTW  matches required to finish; 0 = finish immediately
cfg_timeout  in  TOW  cycles without a match before timeout; 0 = disabled
start  in  1  one-cycle run request; latches all cfg_* inputs
abort  in  1  cancel the run and return to IDLE
in_valid  in  1  in_bit qualifier
in_bit  in  1  serial data
match  out  1  combinational pulse: the current valid bit completes the pattern
busy  out  1  state == RUN
done  out  1  target reached; held in DONE
timeout  out  1  timeout ended the run; held in DONE
cfg_err  out  1  one-cycle pulse: start was rejected because cfg_len was invalid
match_count  out  CNTW  matches counted in the current or last run

Behaviour:
- States: IDLE, RUN, DONE. On reset: state IDLE; match_count, history, fill counter and timeout counter all 0; busy, done, timeout and cfg_err 0.
- IDLE or DONE, start=1, abort=0, cfg_len in 1..MAXLEN:
  - latch the configuration;
  - clear match_count, history, fill and timeout counter;
  - clear done and timeout;
  - go to RUN.
- Same condition with cfg_len=0 or cfg_len>MAXLEN: cfg_err=1 for the next cycle; state and status unchanged.
- start while in RUN: ignored.
- abort: RUN or DONE → IDLE next edge; done and timeout cleared; match_count held. abort wins over a simultaneous start.
- History: shift register of the last MAXLEN-1 valid bits, plus a fill counter that saturates at MAXLEN-1. It updates only on cycles where in_valid=1 in RUN.
- match = busy & in_valid & (fill >= len-1) & ({history, in_bit} low len bits == pattern low len bits). match is combinational, in the same cycle as the completing bit. len=1 compares in_bit alone.
- On a match:
  - match_count increments at the next edge;
  - non-overlapping mode: fill resets to 0, so the completing bit is not reused;
  - overlapping mode: fill keeps advancing.
- Target:
  - When the increment makes match_count == target, state goes to DONE at that same edge, so done is high in the following cycle. No further matches are counted.
  - target=0: RUN lasts exactly one cycle, then DONE. match is suppressed in that cycle.
- Timeout counter:
  - increments every RUN cycle, whether or not in_valid is high;
  - clears on a match;
  - when it reaches cfg_timeout (nonzero), go to DONE with timeout=1 and done=0.
  - A match in the same cycle as the counter reaching its limit wins: counter clears, no timeout.
- in_valid=0 cycles: no shift, no match. The timeout counter still advances.
- Reset mid-run: immediate return to IDLE with all reset values at that edge.

Decomposition:
- Package seq_det_pkg:
  - state enum {IDLE, RUN, DONE};
  - default constants for MAXLEN, LENW, CNTW, TOW;
  - function valid_len(len).
- One sub-module, seq_match_core, holds the history register, the fill counter and the length-masked comparator. Its ports are clk, rstn, clr, shift_en, in_bit, pattern, len, overlap, and its output is match.
- FSM, counters and status flags stay in seq_det_ctrl.

Test Plan:
- Non-overlapping "101": pattern=8'h05, len=3, overlap=0, target=4, stream 1,0,1,0,1 all valid → match only on the 3rd bit; match_count=1; busy stays 1.
- Overlapping, same stream with overlap=1, target=2 → match on the 3rd and 5th bits; done=1 in the cycle after the 5th bit; busy=0.
- Timeout: timeout=5, target=1, in_valid held 0 → DONE after 5 RUN cycles with timeout=1, done=0, match_count=0.
- Gaps and 8-bit pattern: pattern=8'hA5, len=8, with in_valid toggling → exactly one match, on the 8th valid bit; cycles with in_valid=0 do not disturb the history.
- Config edge cases:
  - cfg_len=0 → cfg_err pulse, state stays IDLE;
  - cfg_len=9 → same as cfg_len=0;
  - target=0 → busy for one cycle, then done=1.
- Control collisions:
  - abort asserted with start in IDLE → stays IDLE;
  - abort in RUN after 2 matches → IDLE, match_count=2, done=0;
  - rstn=0 mid-run → IDLE, match_count=0.
